// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared types and constants for the RSA modular exponentiation sequencer
//
// Holds the operation and FSM state encodings used by rsa_modexp_ctrl.
// RSA_WIDTH and MM_LATENCY describe the default multiplier pairing and are
// only consumed by verification code.
package rsa_pkg;

    typedef enum logic [2:0] {
        OP_TO_M,
        OP_INIT,
        OP_SQR,
        OP_MUL,
        OP_FROM
    } op_t;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        LOAD,
        RUN,
        DONE
    } state_t;

    localparam int RSA_WIDTH  = 256;
    localparam int MM_LATENCY = 131;

endpackage

// File: rtl/rsa_modexp_ctrl.sv
// rtl/rsa_modexp_ctrl.sv - square-and-multiply sequencer driving an external Montgomery multiplier
//
// Computes result = msg^exp mod modulus. Operands are moved into the
// Montgomery domain with r2_mod (= 2^(2*WIDTH) mod modulus), the exponent is
// scanned MSB-first, and the result is converted back with a multiply by 1.
//
// Optional build macro: RSA_MODEXP_SKIP_LZ_EN
//   When defined, leading zero exponent bits are skipped one per cycle in the
//   SCAN state before the first square (not constant time).
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             one-cycle request, sampled only in IDLE
//   msg, exp          base and exponent, latched on acceptance
//   modulus, r2_mod   odd modulus and 2^(2*WIDTH) mod modulus, latched on acceptance
//   busy              high while an exponentiation is in flight
//   done              one-cycle completion pulse
//   result            final value, held until the next completion
//   mm_a, mm_b, mm_n  multiplier operands and modulus
//   mm_beg            multiplier run enable
//   mm_out            multiplier result
//   mm_out_ready_n    multiplier status, 0 = mm_out valid
module rsa_modexp_ctrl #(
    parameter int WIDTH    = 256,
    parameter int EXP_BITS = 256,
    parameter int IDXW     = 9
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [WIDTH-1:0]    msg,
    input  logic [EXP_BITS-1:0] exp,
    input  logic [WIDTH-1:0]    modulus,
    input  logic [WIDTH-1:0]    r2_mod,
    output logic                busy,
    output logic                done,
    output logic [WIDTH-1:0]    result,
    output logic [WIDTH-1:0]    mm_a,
    output logic [WIDTH-1:0]    mm_b,
    output logic [WIDTH-1:0]    mm_n,
    output logic                mm_beg,
    input  logic [WIDTH-1:0]    mm_out,
    input  logic                mm_out_ready_n
);

    import rsa_pkg::*;

    localparam logic [IDXW-1:0]  IDX_TOP = IDXW'(EXP_BITS - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    state_t              r_state, w_state_nxt;
    op_t                 r_op, w_op_nxt;
    logic [IDXW-1:0]     r_idx, w_idx_nxt;
    // Exponent is kept as a left-shifting register: the bit under scan is
    // always the MSB, so no variable bit select is needed.
    logic [EXP_BITS-1:0] r_exp, w_exp_nxt;
    logic [WIDTH-1:0]    r_msg, r_mod, r_r2, r_mbar, r_x, r_result;

    logic                w_cur_bit;
    logic                w_last;
    logic                w_mm_done;

    assign w_cur_bit = r_exp[EXP_BITS-1];
    assign w_last    = (r_idx == '0);
    assign w_mm_done = (r_state == RUN) && !mm_out_ready_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_op     <= OP_TO_M;
            r_idx    <= '0;
            r_exp    <= '0;
            r_msg    <= '0;
            r_mod    <= '0;
            r_r2     <= '0;
            r_mbar   <= '0;
            r_x      <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_op    <= w_op_nxt;
            r_idx   <= w_idx_nxt;
            r_exp   <= w_exp_nxt;
            if (r_state == IDLE && start) begin
                r_msg <= msg;
                r_mod <= modulus;
                r_r2  <= r2_mod;
            end
            if (w_mm_done) begin
                case (r_op)
                    OP_TO_M: r_mbar   <= mm_out;
                    OP_FROM: r_result <= mm_out;
                    default: r_x      <= mm_out;
                endcase
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_idx_nxt   = r_idx;
        w_exp_nxt   = r_exp;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = LOAD;
                    w_op_nxt    = OP_TO_M;
                    w_idx_nxt   = IDX_TOP;
                    w_exp_nxt   = exp;
                end
            end
            LOAD: w_state_nxt = RUN;
            RUN: begin
                if (!mm_out_ready_n) begin
                    w_state_nxt = LOAD;
                    case (r_op)
                        OP_TO_M: w_op_nxt = OP_INIT;
                        OP_INIT: begin
`ifdef RSA_MODEXP_SKIP_LZ_EN
                            if (w_cur_bit) begin
                                w_op_nxt = OP_SQR;
                            end else begin
                                w_state_nxt = SCAN;
                            end
`else
                            w_op_nxt = OP_SQR;
`endif
                        end
                        OP_SQR: begin
                            if (w_cur_bit) begin
                                w_op_nxt = OP_MUL;
                            end else if (w_last) begin
                                w_op_nxt = OP_FROM;
                            end else begin
                                w_op_nxt  = OP_SQR;
                                w_idx_nxt = r_idx - 1'b1;
                                w_exp_nxt = r_exp << 1;
                            end
                        end
                        OP_MUL: begin
                            // Stop at bit 0 rather than letting idx wrap.
                            if (w_last) begin
                                w_op_nxt = OP_FROM;
                            end else begin
                                w_op_nxt  = OP_SQR;
                                w_idx_nxt = r_idx - 1'b1;
                                w_exp_nxt = r_exp << 1;
                            end
                        end
                        OP_FROM: w_state_nxt = DONE;
                        default: w_state_nxt = IDLE;
                    endcase
                end
            end
`ifdef RSA_MODEXP_SKIP_LZ_EN
            SCAN: begin
                // The current bit is known zero; look one bit ahead so the
                // cycle count equals the number of skipped bits.
                if (w_last) begin
                    w_state_nxt = LOAD;
                    w_op_nxt    = OP_FROM;
                end else begin
                    w_idx_nxt = r_idx - 1'b1;
                    w_exp_nxt = r_exp << 1;
                    if (r_exp[EXP_BITS-2]) begin
                        w_state_nxt = LOAD;
                        w_op_nxt    = OP_SQR;
                    end
                end
            end
`endif
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand mux is purely a function of op and registers that only change
    // at the capture edge, so mm_a/mm_b are stable across LOAD and RUN.
    always_comb begin
        mm_a = '0;
        mm_b = '0;
        if (r_state == LOAD || r_state == RUN) begin
            case (r_op)
                OP_TO_M: begin mm_a = r_msg; mm_b = r_r2;   end
                OP_INIT: begin mm_a = r_r2;  mm_b = ONE;    end
                OP_SQR:  begin mm_a = r_x;   mm_b = r_x;    end
                OP_MUL:  begin mm_a = r_x;   mm_b = r_mbar; end
                OP_FROM: begin mm_a = r_x;   mm_b = ONE;    end
                default: begin mm_a = '0;    mm_b = '0;     end
            endcase
        end
    end

    assign mm_n   = r_mod;
    assign mm_beg = (r_state == RUN);
    assign busy   = (r_state == LOAD) || (r_state == RUN) || (r_state == SCAN);
    assign done   = (r_state == DONE);
    assign result = r_result;

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// tb/tb_rsa_modexp_ctrl.sv - directed self-checking bench for rsa_modexp_ctrl with a behavioural Montgomery multiplier
module tb_rsa_modexp_ctrl;

    import rsa_pkg::*;

    localparam int W  = RSA_WIDTH;
    localparam int EB = 8;
    localparam int IW = 4;
    localparam int LIMIT = 5000;

`ifdef RSA_MODEXP_SKIP_LZ_EN
    localparam int LAT_E3 = 931;
    localparam int LAT_E2 = 799;
    localparam int LAT_E0 = 405;
    localparam int LAT_E5 = 1062;
    localparam int OPS_E3 = 7;
    localparam int OPS_E0 = 3;
`else
    localparam int LAT_E3 = 1717;
    localparam int LAT_E2 = 1585;
    localparam int LAT_E0 = 1453;
    localparam int LAT_E5 = 1717;
    localparam int OPS_E3 = 13;
    localparam int OPS_E0 = 11;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  msg = '0;
    logic [EB-1:0] exp_i = '0;
    logic [W-1:0]  modulus = '0;
    logic [W-1:0]  r2_mod = '0;
    logic          busy, done, mm_beg, mm_out_ready_n;
    logic [W-1:0]  result, mm_a, mm_b, mm_n, mm_out;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int lat = 0;

    rsa_modexp_ctrl #(.WIDTH(W), .EXP_BITS(EB), .IDXW(IW)) dut (
        .clk(clk), .reset(reset), .start(start), .msg(msg), .exp(exp_i),
        .modulus(modulus), .r2_mod(r2_mod), .busy(busy), .done(done),
        .result(result), .mm_a(mm_a), .mm_b(mm_b), .mm_n(mm_n),
        .mm_beg(mm_beg), .mm_out(mm_out), .mm_out_ready_n(mm_out_ready_n)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] n);
        logic [W+1:0] t;
        t = '0;
        for (int i = 0; i < W; i++) begin
            if (a[i]) t = t + {2'b0, b};
            if (t[0]) t = t + {2'b0, n};
            t = t >> 1;
        end
        if (t >= {2'b0, n}) t = t - {2'b0, n};
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] b, input logic [EB-1:0] e,
                                                input logic [W-1:0] n);
        logic [2*W-1:0] r, bb, nn;
        nn = {{W{1'b0}}, n};
        bb = {{W{1'b0}}, b};
        r  = 1 % nn;
        for (int i = EB - 1; i >= 0; i--) begin
            r = (r * r) % nn;
            if (e[i]) r = (r * bb) % nn;
        end
        return r[W-1:0];
    endfunction

    function automatic int exp_lat(input logic [EB-1:0] e);
        int pop;
        int msb;
        pop = $countones(e);
        msb = -1;
        for (int i = 0; i < EB; i++) if (e[i]) msb = i;
`ifdef RSA_MODEXP_SKIP_LZ_EN
        return 132 * (3 + msb + 1 + pop) + 1 + (EB - 1 - msb);
`else
        if (msb > EB) return 0;
        return 132 * (3 + EB + pop) + 1;
`endif
    endfunction

    // Behavioural multiplier: captures operands while mm_beg is low and
    // raises ready on the MM_LATENCY-th run cycle.
    int           mm_cnt = 0;
    int           op_cnt = 0;
    int           stab_err = 0;
    int           gap = 0;
    int           gap_err = 0;
    logic [W-1:0] m_a = '0, m_b = '0, m_p = '0;

    always @(posedge clk) begin
        if (!mm_beg) begin
            mm_cnt <= 0;
            m_a    <= mm_a;
            m_b    <= mm_b;
            m_p    <= mont(mm_a, mm_b, mm_n);
            if (busy) gap <= gap + 1;
        end else begin
            if (mm_cnt == 0) begin
                op_cnt <= op_cnt + 1;
                if (gap != 1) gap_err <= gap_err + 1;
            end
            if (mm_cnt < 1000) mm_cnt <= mm_cnt + 1;
            if (mm_a !== m_a || mm_b !== m_b) stab_err <= stab_err + 1;
            gap <= 0;
        end
    end

    assign mm_out_ready_n = !(mm_beg && mm_cnt == MM_LATENCY - 1);
    assign mm_out         = m_p;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic start_op(input logic [W-1:0] m, input logic [EB-1:0] e,
                            input logic [W-1:0] n, input logic [W-1:0] r2);
        @(negedge clk);
        msg = m; exp_i = e; modulus = n; r2_mod = r2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
    endtask

    task automatic wait_done(output int l);
        while (!done && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        l = done ? cyc : -1;
    endtask

    initial begin
        int ops0, stab0, gap0;
        logic [W-1:0]   rm, rn, rr2;
        logic [EB-1:0]  re;
        logic [2*W:0]   big;

        repeat (3) @(negedge clk);
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_result", result, W'(0));
        chk("rst_mm_beg", W'(mm_beg), W'(0));
        chk("rst_mm_a", mm_a, W'(0));
        chk("rst_mm_b", mm_b, W'(0));
        reset = 1'b0;

        // 2^3 mod 13 = 8
        ops0 = op_cnt; stab0 = stab_err;
        start_op(W'(2), EB'(3), W'(13), W'(9));
        chk("t1_busy", W'(busy), W'(1));
        wait_done(lat);
        chk("t1_latency", W'(lat), W'(LAT_E3));
        chk("t1_done_busy", W'(busy), W'(0));
        chk("t1_result", result, W'(8));
        chk("t1_ops", W'(op_cnt - ops0), W'(OPS_E3));
        chk("t1_stable", W'(stab_err - stab0), W'(0));
        @(negedge clk);
        chk("t1_done_pulse", W'(done), W'(0));
        chk("t1_result_held", result, W'(8));

        // 12^2 mod 13 = 1
        gap0 = gap_err;
        start_op(W'(12), EB'(2), W'(13), W'(9));
        wait_done(lat);
        chk("t2_latency", W'(lat), W'(LAT_E2));
        chk("t2_result", result, W'(1));
`ifndef RSA_MODEXP_SKIP_LZ_EN
        chk("t2_gap", W'(gap_err - gap0), W'(0));
`endif

        // exp=0 gives 1, with no MUL issued
        ops0 = op_cnt;
        start_op(W'(5), EB'(0), W'(13), W'(9));
        wait_done(lat);
        chk("t3_latency", W'(lat), W'(LAT_E0));
        chk("t3_result", result, W'(1));
        chk("t3_ops", W'(op_cnt - ops0), W'(OPS_E0));

        // msg=0, exp>0 gives 0
        start_op(W'(0), EB'(6), W'(13), W'(9));
        wait_done(lat);
        chk("t3b_result", result, W'(0));

        // reset during 100th RUN cycle
        start_op(W'(2), EB'(3), W'(13), W'(9));
        while (!(mm_beg && mm_cnt == 99) && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        chk("t4_reached_run100", W'(mm_beg && mm_cnt == 99), W'(1));
        reset = 1'b1;
        @(negedge clk);
        chk("t4_busy", W'(busy), W'(0));
        chk("t4_mm_beg", W'(mm_beg), W'(0));
        chk("t4_done", W'(done), W'(0));
        reset = 1'b0;
        @(negedge clk);
        chk("t4_no_done", W'(done), W'(0));
        // 3^5 mod 13 = 9
        start_op(W'(3), EB'(5), W'(13), W'(9));
        wait_done(lat);
        chk("t4_latency", W'(lat), W'(LAT_E5));
        chk("t4_result", result, W'(9));

        // start while busy is ignored; inputs change after acceptance
        start_op(W'(2), EB'(3), W'(13), W'(9));
        repeat (5) begin @(negedge clk); cyc++; end
        msg = W'(7); exp_i = EB'(8'hFF); modulus = W'(11); r2_mod = W'(3); start = 1'b1;
        @(negedge clk);
        cyc++;
        start = 1'b0;
        msg = W'(4); exp_i = EB'(8'h81);
        wait_done(lat);
        chk("t5_latency", W'(lat), W'(LAT_E3));
        chk("t5_result", result, W'(8));
        @(negedge clk);
        chk("t5_idle", W'(busy), W'(0));

        // random 256-bit vectors against a plain bignum reference
        for (int v = 0; v < 3; v++) begin
            for (int k = 0; k < W / 32; k++) begin
                rn[k*32 +: 32] = $urandom;
                rm[k*32 +: 32] = $urandom;
            end
            rn[0] = 1'b1;
            rn[W-1] = 1'b1;
            rm = rm % rn;
            re = EB'($urandom);
            big = '0;
            big[2*W] = 1'b1;
            big = big % {{(W+1){1'b0}}, rn};
            rr2 = big[W-1:0];
            start_op(rm, re, rn, rr2);
            wait_done(lat);
            chk($sformatf("rnd%0d_result", v), result, ref_modexp(rm, re, rn));
            chk($sformatf("rnd%0d_latency", v), W'(lat), W'(exp_lat(re)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
